// File: rtl/lcg_rr_server.sv
// lcg_rr_server: one shared 32-bit LCG served to NUM_REQ requesters through a
// round-robin arbiter. The state advances only when a sample is handed out or
// during the discard warm-up that follows reset and every reseed.
module lcg_rr_server #(
    parameter int          NUM_REQ = 4,
    parameter logic [31:0] SEED0   = 32'd1634404289,
    parameter logic [63:0] MUL     = 64'd69069,
    parameter logic [31:0] ADD     = 32'd1234567,
    parameter int          WARMUP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [31:0]                rnd_data,
    output logic [$clog2(NUM_REQ)-1:0] rnd_id,
    input  logic                       reseed_valid,
    input  logic [31:0]                reseed_data,
    output logic                       ready,
    output logic [31:0]                draw_count,
    output logic [0:0]                 state_dbg
);

    // Handshake: req[i] is a level request that the requester holds until it
    // sees gnt[i] high; the sample is rnd_data in that same cycle and the
    // request is considered consumed at the following clock edge.
    // reseed_valid is always accepted (no ready) and blocks any grant in its
    // cycle, so a colliding request simply stays pending.

    localparam int               IDW         = $clog2(NUM_REQ);
    localparam logic [0:0]       ST_WARMUP   = 1'b0;
    localparam logic [0:0]       ST_SERVE    = 1'b1;
    localparam logic [7:0]       WARMUP_CNT  = 8'(WARMUP);
    localparam logic [0:0]       START_STATE = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;
    localparam logic [IDW-1:0]   PTR_INIT    = IDW'(NUM_REQ - 1);
    localparam logic [IDW:0]     NUM_REQ_W   = (IDW+1)'(NUM_REQ);

    logic [0:0]     state;
    logic [7:0]     cnt;
    logic [31:0]    s;
    logic [31:0]    s_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_idx;
    logic           found;
    logic           grant_ok;
    logic [IDW:0]   cand_w;
    logic [IDW-1:0] cand;

    // LCG step: 64-bit product plus increment, truncated to 32 bits.
    assign s_next = 32'(MUL * {32'b0, s} + {32'b0, ADD});

    // Round-robin search: first set request scanning upward from ptr+1 with wrap.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand_w  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_w = {1'b0, ptr} + k[IDW:0];
            if (cand_w >= NUM_REQ_W) cand_w = cand_w - NUM_REQ_W;
            cand = cand_w[IDW-1:0];
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant decode: only in SERVE, never under reset or while a reseed is taken.
    always_comb begin
        grant_ok = !rst && !reseed_valid && (state == ST_SERVE) && found;
        gnt      = '0;
        rnd_id   = '0;
        if (grant_ok) begin
            gnt[win_idx] = 1'b1;
            rnd_id       = win_idx;
        end
    end

    assign ready      = !rst && (state == ST_SERVE);
    assign rnd_data   = s;
    assign state_dbg  = state;

    // State, warm-up counter, arbitration pointer and draw counter updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            s          <= SEED0;
            ptr        <= PTR_INIT;
            draw_count <= '0;
            cnt        <= WARMUP_CNT;
            state      <= START_STATE;
        end else if (reseed_valid) begin
            s     <= reseed_data;
            cnt   <= WARMUP_CNT;
            state <= START_STATE;
        end else if (state == ST_WARMUP) begin
            s   <= s_next;
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) state <= ST_SERVE;
        end else if (grant_ok) begin
            s          <= s_next;
            ptr        <= win_idx;
            draw_count <= draw_count + 32'd1;
        end
    end

endmodule
